freq_gate_ctrl: RTL
===================

// Module: freq_gate_ctrl
// PURPOSE
//  Gate-time frequency-meter controller that sits directly downstream of input_capture.
//  - Drives input_capture's i_clr and i_cnt_en.
//  - Opens a counting window of programmable length (in sysclk cycles).
//  - Latches the 16-bit pulse count at window end and presents it through a valid/ack result register.
//  - Supports single-shot and continuous measurement, with abort and missed-result reporting.
// PARAMETERS
//  GATE_W        24          width of gate-length counter / i_gate_len
//  CNT_W         16          width of pulse count (matches input_capture o_cnt_data)
// PORTS
//  i_sysclk      in   1      system clock; all state on rising edge
//  i_sysrst_n    in   1      system reset, asynchronous, active-low
//  i_start       in   1      start request, sampled in IDLE only
//  i_stop        in   1      abort; highest priority after reset
//  i_cont        in   1      continuous mode: re-arm after each result
//  i_gate_len    in   GATE_W gate length in cycles, sampled on accepted start/re-arm
//  i_cnt_data    in   CNT_W  count from input_capture o_cnt_data
//  o_clr         out  1      to input_capture i_clr
//  o_cnt_en      out  1      to input_capture i_cnt_en
//  o_busy        out  1      1 in any state except IDLE
//  o_res_valid   out  1      result available
//  i_res_ack     in   1      consumer accepts result (effective only while o_res_valid=1)
//  o_res_data    out  CNT_W  latched count
//  o_res_ovf     out  1      count wrapped during the window (see CONFIGURATION)
//  o_miss        out  1      sticky: unacked result was overwritten
// BEHAVIOUR
//  Reset: asynchronous, active-low.
//  - All outputs 0, state IDLE, gate counter 0.
//  - Assertion mid-operation forces this immediately; no result is produced.
//  Outputs: registered Moore decode of the registered state; glitch-free.
//  States: IDLE -> CLEAR -> GATE -> SETTLE -> LATCH -> (CLEAR if i_cont else IDLE)
//  - IDLE: i_start=1 -> CLEAR. Gate counter loads max(i_gate_len,1), so a length of 0 is treated as 1.
//  - CLEAR: one cycle, o_clr=1, o_cnt_en=0 -> GATE.
//  - GATE: o_cnt_en=1 for exactly N cycles, then -> SETTLE (gate counter decrements, exits at 1).
//  - SETTLE: one cycle, o_cnt_en=0; lets the final count update land -> LATCH.
//  - LATCH: samples i_cnt_data into o_res_data, sets o_res_valid (and o_res_ovf).
//    - i_cont=1: reload from i_gate_len and go to CLEAR.
//    - i_cont=0: go to IDLE.
//  Timing: i_start sampled at edge k.
//  - o_clr=1 in cycle k+1.
//  - o_cnt_en=1 in cycles k+2..k+N+1.
//  - o_res_valid=1 from cycle k+N+4.
//  i_start outside IDLE: ignored. i_cont dropped mid-run: current run completes, then IDLE.
//  i_stop in any non-IDLE state:
//  - Next state is IDLE; o_cnt_en and o_clr low from the next cycle.
//  - No new result; an existing valid result is kept.
//  Result handshake:
//  - o_res_valid & i_res_ack at an edge: o_res_valid->0 and o_miss->0 at that edge.
//  - LATCH while o_res_valid=1 and no ack: data overwritten, o_miss->1 (sticky).
//  - LATCH and ack on the same edge: new result wins, o_res_valid stays 1, o_miss->0.
//  Arithmetic:
//  - Gate counter is unsigned GATE_W and never wraps (loads >= 1).
//  - The count is taken verbatim; modulo 2^CNT_W.
// CONFIGURATION
//  Macro FREQ_GATE_OVF_DET_EN.
//  Defined:
//  - Registers the previous i_cnt_data during GATE and SETTLE.
//  - prev==all-ones && cur==0 sets an internal sticky wrap bit. The bit clears in CLEAR.
//  - LATCH copies the wrap bit to o_res_ovf, held with o_res_data.
//  Undefined: no wrap logic; o_res_ovf is tied to 0.
// STRUCTURE
//  Package freq_gate_pkg:
//  - state enum {IDLE, CLEAR, GATE, SETTLE, LATCH}
//  - GATE_W_DEF = 24, CNT_W_DEF = 16
//  Sub-module gate_timer: loadable GATE_W down-counter with load/en inputs and an o_last flag.
//  FSM, result register and wrap detector stay in freq_gate_ctrl.
// TESTING (chained with input_capture, pulse source on i_cap_pin)
//  1. gate_len=100, pulse period 10 clk, single shot
//     -> o_clr 1 cycle, o_cnt_en 100 cycles, o_res_data=10 +/-1, valid at start+104.
//  2. gate_len=0, no pulses
//     -> o_cnt_en high exactly 1 cycle, o_res_data=0, valid at start+5, o_busy=0 after.
//  3. i_cont=1, gate_len=50, never ack
//     -> second LATCH sets o_miss=1, valid stays 1; one ack clears both.
//  4. gate_len=200000, pulse period 2 clk
//     -> 100000 pulses; o_res_data=100000-65536=34464 +/-1.
//     -> o_res_ovf=1 with FREQ_GATE_OVF_DET_EN, 0 without.
//  5. i_sysrst_n low mid-GATE
//     -> all outputs 0 asynchronously; after release IDLE, o_busy=0, no valid.
//  6. i_stop at GATE cycle 20 of 100
//     -> IDLE next cycle, o_cnt_en=0, no new o_res_valid; earlier result retained.

Source files
------------

// File: rtl/freq_gate_ctrl_pkg.sv
// Shared definitions for the gate-time frequency-meter controller:
// default widths and the measurement state encoding.
package freq_gate_pkg;

   localparam int GATE_W_DEF = 24;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_GATE   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_LATCH  = 3'd4
   } state_e;

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// gate_timer: loadable down-counter that measures the counting window.
// o_last is high while the counter holds 1, i.e. during the final window cycle.
module gate_timer
   import freq_gate_pkg::*;
#(
   parameter int GATE_W = GATE_W_DEF
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst_n,
   input  logic              i_load,
   input  logic              i_en,
   input  logic [GATE_W-1:0] i_load_val,
   output logic              o_last
);

   logic [GATE_W-1:0] cnt_q;

   // Load the window length, then count down once per enabled cycle; never wraps below 0.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= i_load_val;
      end else if (i_en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - GATE_W'(1);
      end
   end

   assign o_last = (cnt_q == GATE_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-time frequency-meter controller placed after input_capture.
// Clears the capture counter, opens a window of programmable length, latches the
// pulse count at window end and offers it through a valid/ack result register.
// Optional feature macro FREQ_GATE_OVF_DET_EN: detects the pulse count wrapping
// during the window and reports it on o_res_ovf (tied to 0 when undefined).
module freq_gate_ctrl
   import freq_gate_pkg::*;
#(
   parameter int GATE_W = GATE_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst_n,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_cont,
   input  logic [GATE_W-1:0] i_gate_len,
   input  logic [CNT_W-1:0]  i_cnt_data,
   output logic              o_clr,
   output logic              o_cnt_en,
   output logic              o_busy,
   output logic              o_res_valid,
   input  logic              i_res_ack,
   output logic [CNT_W-1:0]  o_res_data,
   output logic              o_res_ovf,
   output logic              o_miss
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_CLEAR  = ST_CLEAR;
   localparam logic [2:0] S_GATE   = ST_GATE;
   localparam logic [2:0] S_SETTLE = ST_SETTLE;
   localparam logic [2:0] S_LATCH  = ST_LATCH;

   // A zero length would never reach the last-cycle flag, so it is floored to 1.
   function automatic logic [GATE_W-1:0] floor_len(input logic [GATE_W-1:0] len);
      return (len == '0) ? GATE_W'(1) : len;
   endfunction

   logic [2:0]        state_q;
   logic [2:0]        state_d;
   logic              gate_load;
   logic              gate_en;
   logic              gate_last;
   logic              latch_evt;
   logic [GATE_W-1:0] gate_len_fl;

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (i_start) state_d = S_CLEAR;
         S_CLEAR:  state_d = S_GATE;
         S_GATE:   if (gate_last) state_d = S_SETTLE;
         S_SETTLE: state_d = S_LATCH;
         S_LATCH:  state_d = i_cont ? S_CLEAR : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (i_stop) state_d = S_IDLE;
   end

   // State register.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   // Every entry into CLEAR (fresh start or continuous re-arm) reloads the window length.
   assign gate_load   = (state_d == S_CLEAR);
   assign gate_en     = (state_q == S_GATE);
   assign gate_len_fl = floor_len(i_gate_len);
   assign latch_evt   = (state_q == S_LATCH) && !i_stop;

   gate_timer #(.GATE_W(GATE_W)) u_gate_timer (
      .i_sysclk   (i_sysclk),
      .i_sysrst_n (i_sysrst_n),
      .i_load     (gate_load),
      .i_en       (gate_en),
      .i_load_val (gate_len_fl),
      .o_last     (gate_last)
   );

   // Control outputs registered from the next state so they align with the state and never glitch.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         o_busy   <= 1'b0;
         o_clr    <= 1'b0;
         o_cnt_en <= 1'b0;
      end else begin
         o_busy   <= (state_d != S_IDLE);
         o_clr    <= (state_d == S_CLEAR);
         o_cnt_en <= (state_d == S_GATE);
      end
   end

   // Result register: a new latch wins over a same-edge ack; an overwritten unacked result sets o_miss.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_miss      <= 1'b0;
      end else if (latch_evt) begin
         o_res_valid <= 1'b1;
         o_res_data  <= i_cnt_data;
         if (o_res_valid && !i_res_ack)     o_miss <= 1'b1;
         else if (o_res_valid && i_res_ack) o_miss <= 1'b0;
      end else if (o_res_valid && i_res_ack) begin
         o_res_valid <= 1'b0;
         o_miss      <= 1'b0;
      end
   end

`ifdef FREQ_GATE_OVF_DET_EN
   logic [CNT_W-1:0] cnt_data_p1;
   logic             vld_p1;
   logic             wrap_q;
   logic             wrap_now;
   logic             res_ovf_q;

   // Stage p1: previous count sample, kept while the count can still move.
   always_ff @(posedge i_sysclk) begin
      if ((state_q == S_GATE) || (state_q == S_SETTLE)) cnt_data_p1 <= i_cnt_data;
   end

   // vld_p1 marks that cnt_data_p1 belongs to the current window, so a stale sample never compares.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) vld_p1 <= 1'b0;
      else             vld_p1 <= (state_q == S_GATE) || (state_q == S_SETTLE);
   end

   // The last pair (SETTLE sample vs LATCH sample) is still checked in LATCH.
   assign wrap_now = vld_p1 && (cnt_data_p1 == '1) && (i_cnt_data == '0)
                     && ((state_q == S_GATE) || (state_q == S_SETTLE) || (state_q == S_LATCH));

   // Sticky wrap flag for the current window, cleared when the capture counter is cleared.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n)              wrap_q <= 1'b0;
      else if (state_q == S_CLEAR)  wrap_q <= 1'b0;
      else if (wrap_now)            wrap_q <= 1'b1;
   end

   // Wrap flag travels with the latched data.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n)    res_ovf_q <= 1'b0;
      else if (latch_evt) res_ovf_q <= wrap_q | wrap_now;
   end

   assign o_res_ovf = res_ovf_q;
`else
   assign o_res_ovf = 1'b0;
`endif

endmodule
